// File: rtl/egg_timer_countdown_pkg.sv
// egg_timer_pkg: definitions shared by the egg-timer control FSM and the
// countdown stage. It holds the countdown state encoding and the per-digit
// BCD limits.
package egg_timer_pkg;

    typedef enum logic [1:0] {
        LOADED   = 2'd0,
        COUNTING = 2'd1,
        EXPIRED  = 2'd2
    } timer_state_e;

    localparam int BCD_SEC_ONES_MAX = 9;
    localparam int BCD_SEC_TENS_MAX = 5;
    localparam int BCD_MIN_ONES_MAX = 9;

endpackage

// File: rtl/egg_timer_countdown_bcd_down_digit.sv
// bcd_down_digit: one decimal digit of a down-counter with load and borrow.
//   clk        in   clock
//   rst        in   synchronous active-high reset (digit -> 0)
//   load_en    in   load load_val (clamped to MAX); wins over dec_en
//   load_val   in   value to load
//   dec_en     in   decrement this cycle (borrow from the digit below)
//   digit      out  registered digit value
//   borrow_out out  this digit wraps 0 -> MAX, so the next digit must decrement
module bcd_down_digit #(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en,
    input  logic [3:0] load_val,
    input  logic       dec_en,
    output logic [3:0] digit,
    output logic       borrow_out
);

    localparam logic [3:0] MAX_V = 4'(MAX);

    logic [3:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_en) begin
            digit_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (dec_en) begin
            digit_d = (digit_q == 4'd0) ? MAX_V : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) digit_q <= '0;
        else     digit_q <= digit_d;
    end

    assign digit      = digit_q;
    assign borrow_out = dec_en && (digit_q == 4'd0);

endmodule

// File: rtl/egg_timer_countdown.sv
// egg_timer_countdown: BCD mm:ss countdown stage below the egg-timer FSM.
// It captures the load digits, counts down once per 1 Hz tick, pulses
// cook_time when the count reaches 00:00 and then holds a timed alarm request.
//   pulse_500Hz            in   clock
//   reset                  in   synchronous active-high reset
//   tick_1Hz               in   one-cycle strobe, once per second
//   enable_load            in   capture the load_* digits
//   enable_timer_countdown in   countdown permitted (0 = pause)
//   load_*                 in   BCD load digits (out-of-range values clamp)
//   alarm_ack              in   silence the alarm
//   second_/minute_*       out  remaining time, BCD, registered
//   cook_time              out  one-cycle completion pulse
//   timer_running          out  counting and enabled
//   alarm_on               out  alarm request to the audio block
module egg_timer_countdown
    import egg_timer_pkg::*;
#(
    parameter int ALARM_SECONDS   = 10,
    parameter int MINUTE_TENS_MAX = 5
) (
    input  logic       pulse_500Hz,
    input  logic       reset,
    input  logic       tick_1Hz,
    input  logic       enable_load,
    input  logic       enable_timer_countdown,
    input  logic [3:0] load_second_ones,
    input  logic [3:0] load_second_tens,
    input  logic [3:0] load_minute_ones,
    input  logic [3:0] load_minute_tens,
    input  logic       alarm_ack,
    output logic [3:0] second_ones,
    output logic [3:0] second_tens,
    output logic [3:0] minute_ones,
    output logic [3:0] minute_tens,
    output logic       cook_time,
    output logic       timer_running,
    output logic       alarm_on
);

    localparam logic [3:0] ALARM_LAST = 4'(ALARM_SECONDS - 1);

    timer_state_e state_q, state_d;
    logic         cook_q, cook_d;
    logic         alarm_q, alarm_d;
    logic [3:0]   alarm_cnt_q, alarm_cnt_d;
    logic         dec, expire, is_zero;
    logic         b_so, b_st, b_mo;
    logic         mt_borrow_unused;

    // Borrow chain: seconds ones -> seconds tens -> minutes ones -> minutes tens.
    // The top digit never borrows because 00:00 is never decremented.
    bcd_down_digit #(.MAX(BCD_SEC_ONES_MAX)) u_so (
        .clk(pulse_500Hz), .rst(reset), .load_en(enable_load),
        .load_val(load_second_ones), .dec_en(dec),
        .digit(second_ones), .borrow_out(b_so)
    );
    bcd_down_digit #(.MAX(BCD_SEC_TENS_MAX)) u_st (
        .clk(pulse_500Hz), .rst(reset), .load_en(enable_load),
        .load_val(load_second_tens), .dec_en(b_so),
        .digit(second_tens), .borrow_out(b_st)
    );
    bcd_down_digit #(.MAX(BCD_MIN_ONES_MAX)) u_mo (
        .clk(pulse_500Hz), .rst(reset), .load_en(enable_load),
        .load_val(load_minute_ones), .dec_en(b_st),
        .digit(minute_ones), .borrow_out(b_mo)
    );
    bcd_down_digit #(.MAX(MINUTE_TENS_MAX)) u_mt (
        .clk(pulse_500Hz), .rst(reset), .load_en(enable_load),
        .load_val(load_minute_tens), .dec_en(b_mo),
        .digit(minute_tens), .borrow_out(mt_borrow_unused)
    );

    assign is_zero = (second_ones == 4'd0) && (second_tens == 4'd0) &&
                     (minute_ones == 4'd0) && (minute_tens == 4'd0);

    always_comb begin
        state_d     = state_q;
        cook_d      = 1'b0;
        dec         = 1'b0;
        expire      = 1'b0;
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;

        if (enable_load) begin
            state_d = LOADED;
        end else begin
            unique case (state_q)
                LOADED: begin
                    // No decrement on the start cycle, even with a tick.
                    if (enable_timer_countdown) state_d = COUNTING;
                end
                COUNTING: begin
                    if (enable_timer_countdown) begin
                        // Expiry is seen one cycle after the count lands on
                        // 00:00; a tick in that cycle is dropped.
                        if (is_zero) begin
                            state_d = EXPIRED;
                            cook_d  = 1'b1;
                            expire  = 1'b1;
                        end else if (tick_1Hz) begin
                            dec = 1'b1;
                        end
                    end
                end
                EXPIRED: ;
                default: state_d = LOADED;
            endcase
        end

        // Alarm runs on its own: a load does not silence it. A new expiry
        // overrides a simultaneous ack.
        if (expire) begin
            alarm_d     = 1'b1;
            alarm_cnt_d = '0;
        end else if (alarm_q) begin
            if (alarm_ack) begin
                alarm_d     = 1'b0;
                alarm_cnt_d = '0;
            end else if (tick_1Hz) begin
                if (alarm_cnt_q == ALARM_LAST) begin
                    alarm_d     = 1'b0;
                    alarm_cnt_d = '0;
                end else begin
                    alarm_cnt_d = alarm_cnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge pulse_500Hz) begin
        if (reset) begin
            state_q     <= LOADED;
            cook_q      <= 1'b0;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cook_q      <= cook_d;
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    assign cook_time     = cook_q;
    assign alarm_on      = alarm_q;
    assign timer_running = (state_q == COUNTING) && enable_timer_countdown;

endmodule

// File: tb/tb_egg_timer_countdown.sv
module tb_egg_timer_countdown;

    logic       clk = 1'b0;
    logic       reset, tick, en_load, en_cnt, ack;
    logic [3:0] l_so, l_st, l_mo, l_mt;
    logic [3:0] so, st, mo, mt;
    logic       cook, running, alarm;

    int errs   = 0;
    int checks = 0;
    int s;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    egg_timer_countdown #(.ALARM_SECONDS(10), .MINUTE_TENS_MAX(5)) dut (
        .pulse_500Hz(clk), .reset(reset), .tick_1Hz(tick),
        .enable_load(en_load), .enable_timer_countdown(en_cnt),
        .load_second_ones(l_so), .load_second_tens(l_st),
        .load_minute_ones(l_mo), .load_minute_tens(l_mt),
        .alarm_ack(ack),
        .second_ones(so), .second_tens(st), .minute_ones(mo), .minute_tens(mt),
        .cook_time(cook), .timer_running(running), .alarm_on(alarm)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Reference: seconds count -> BCD {mt, mo, st, so}
    function automatic logic [15:0] to_bcd(input int secs);
        int m, sec;
        m   = secs / 60;
        sec = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    task automatic push_exp(input int secs);
        exp_q.push_back(to_bcd(secs));
    endtask

    task automatic pop_cmp(input string tag);
        if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            chk(tag, {16'd0, mt, mo, st, so}, {16'd0, exp_q.pop_front()});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic load(input logic [3:0] a_mt, input logic [3:0] a_mo,
                        input logic [3:0] a_st, input logic [3:0] a_so);
        l_mt = a_mt; l_mo = a_mo; l_st = a_st; l_so = a_so;
        en_load = 1'b1;
        step();
        en_load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; en_load = 1'b0; en_cnt = 1'b0; ack = 1'b0;
        l_so = '0; l_st = '0; l_mo = '0; l_mt = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_digits", {16'd0, mt, mo, st, so}, 32'd0);
        chk("rst_cook", cook, 0);
        chk("rst_run", running, 0);
        chk("rst_alarm", alarm, 0);

        // 01:05 down to 00:00; tick on the start cycle must not decrement
        load(4'd0, 4'd1, 4'd0, 4'd5);
        s = 65; push_exp(s); pop_cmp("load_0105");
        en_cnt = 1'b1;
        tick_step();
        chk("start_run", running, 1);
        push_exp(s); pop_cmp("start_tick_nodec");
        for (int i = 0; i < 65; i++) begin
            s--;
            push_exp(s);
            tick_step();
            pop_cmp("count");
            chk("cook_early", cook, 0);
            step();
            if (s != 0) chk("cook_idle", cook, 0);
        end
        // the idle step after the final tick is the expiry cycle
        chk("cook_pulse", cook, 1);
        chk("alarm_set", alarm, 1);
        chk("expired_run", running, 0);

        // load right after expiry: alarm keeps going for 10 ticks
        en_cnt = 1'b0;
        load(4'd0, 4'd0, 4'd0, 4'd0);
        chk("cook_one_cycle", cook, 0);
        chk("alarm_after_load", alarm, 1);
        for (int i = 0; i < 10; i++) begin
            tick_step();
            chk("alarm_timed", alarm, (i < 9) ? 1 : 0);
        end

        // loaded 00:00: cook on the second edge without any tick
        en_cnt = 1'b1;
        step();
        chk("zero_e1_cook", cook, 0);
        chk("zero_e1_run", running, 1);
        step();
        chk("zero_e2_cook", cook, 1);
        push_exp(0); pop_cmp("zero_hold");
        chk("zero_alarm", alarm, 1);
        en_cnt = 1'b0;
        step();
        chk("zero_cook_off", cook, 0);
        for (int i = 0; i < 3; i++) begin
            tick_step();
            chk("ack_pre", alarm, 1);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_off", alarm, 0);

        // 10:00, 3 ticks, pause 5 ticks, resume 1 tick
        load(4'd1, 4'd0, 4'd0, 4'd0);
        s = 600;
        en_cnt = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            s--; push_exp(s); tick_step(); pop_cmp("run3");
        end
        en_cnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_exp(s); tick_step(); pop_cmp("pause");
            chk("pause_run", running, 0);
        end
        en_cnt = 1'b1;
        s--; push_exp(s); tick_step(); pop_cmp("resume");

        // load coincident with a tick in COUNTING: load wins
        l_mt = 4'd0; l_mo = 4'd0; l_st = 4'd3; l_so = 4'd0;
        en_load = 1'b1; tick = 1'b1;
        step();
        en_load = 1'b0; tick = 1'b0;
        s = 30; push_exp(s); pop_cmp("load_vs_tick");
        chk("load_vs_tick_cook", cook, 0);

        // clamp 12/7/11/9 -> 59:59, then reset mid-count
        en_cnt = 1'b0;
        load(4'd9, 4'd11, 4'd7, 4'd12);
        s = 3599; push_exp(s); pop_cmp("clamp");
        en_cnt = 1'b1;
        step();
        s--; push_exp(s); tick_step(); pop_cmp("clamp_dec");
        reset = 1'b1;
        step();
        chk("midrst_digits", {16'd0, mt, mo, st, so}, 32'd0);
        chk("midrst_cook", cook, 0);
        chk("midrst_run", running, 0);
        chk("midrst_alarm", alarm, 0);
        reset = 1'b0; en_cnt = 1'b0;
        step();
        chk("postrst_cook", cook, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
